tcdm_lrsc_adapter: RTL

Bank-side TCDM adapter with a multi-entry LR/SC reservation table, one instance per SRAM bank in a MemPool tile. It generalises the single-reservation scheme to `NumReservations` concurrent reservations across cores. It enforces credit-based response flow control toward the interconnect and returns responses in order through a bounded response queue.

---
 rtl/tcdm_adapter_pkg.sv | 26 ++
 rtl/fifo_v3.sv | 63 ++++++
 rtl/tcdm_reservation_table.sv | 91 +++++++++
 rtl/tcdm_lrsc_adapter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tcdm_adapter_pkg.sv
// Shared types and constants for the TCDM LR/SC bank adapter.
// Struct field widths match the adapter's default parameters.
package tcdm_adapter_pkg;

    localparam logic [3:0] AmoNone = 4'h0;
    localparam logic [3:0] AmoLR   = 4'hA;
    localparam logic [3:0] AmoSC   = 4'hB;

    localparam int unsigned RsvCoreIdWidth = 8;
    localparam int unsigned RsvWordWidth   = 30;
    localparam int unsigned PipeMetaWidth  = 16;

    typedef struct packed {
        logic                      valid;
        logic [RsvCoreIdWidth-1:0] core_id;
        logic [RsvWordWidth-1:0]   word_addr;
    } reservation_t;

    typedef struct packed {
        logic [PipeMetaWidth-1:0] meta;
        logic                     is_sc;
        logic                     sc_result;
        logic                     has_resp;
    } resp_pipe_t;

endpackage

// File: rtl/fifo_v3.sv
// Small FIFO; in fall-through mode a push into an empty queue is
// visible at the output in the same cycle.
module fifo_v3 #(
    parameter bit          FallThrough = 1'b1,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DataWidth-1:0] data_in,
    input  logic                 pop,
    output logic [DataWidth-1:0] data_out,
    output logic                 empty
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth-1:0] wr_ptr;
    logic [CntWidth-1:0] count;
    logic stored_empty;
    logic bypass;
    logic do_push;
    logic do_pop;

    assign stored_empty = (count == '0);
    assign bypass = FallThrough && stored_empty && push && pop;
    assign empty = stored_empty && !(FallThrough && push);
    assign data_out = (FallThrough && stored_empty) ? data_in : mem[rd_ptr];
    assign do_push = push && (count != CntWidth'(Depth)) && !bypass;
    assign do_pop = pop && !stored_empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcdm_reservation_table.sv
// Multi-entry LR/SC reservation table with round-robin victim replacement.
// Only one of lr/sc/inv is asserted in a given cycle.
module tcdm_reservation_table
    import tcdm_adapter_pkg::*;
#(
    parameter int unsigned NumReservations = 4,
    parameter int unsigned CoreIdWidth     = 8,
    parameter int unsigned WordWidth       = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lr,
    input  logic                   sc,
    input  logic                   inv,
    input  logic [CoreIdWidth-1:0] core_id,
    input  logic [WordWidth-1:0]   word_addr,
    output logic                   sc_ok
);

    localparam int unsigned IdxWidth =
        (NumReservations > 1) ? $clog2(NumReservations) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReservations - 1);

    reservation_t entries [NumReservations];
    reservation_t fresh;
    logic [RsvCoreIdWidth-1:0] cid;
    logic [RsvWordWidth-1:0] wa;
    logic [IdxWidth-1:0] victim;
    logic [IdxWidth-1:0] own_idx;
    logic [IdxWidth-1:0] free_idx;
    logic own_hit;
    logic free_hit;
    logic clear_addr;
    logic clear_core;

    assign cid = RsvCoreIdWidth'(core_id);
    assign wa = RsvWordWidth'(word_addr);
    assign fresh = '{valid: 1'b1, core_id: cid, word_addr: wa};
    assign clear_addr = inv || (sc && sc_ok);
    assign clear_core = sc && !sc_ok;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        own_hit = 1'b0;
        own_idx = '0;
        free_hit = 1'b0;
        free_idx = '0;
        sc_ok = 1'b0;
        for (int i = NumReservations - 1; i >= 0; i--) begin
            if (entries[i].valid && entries[i].core_id == cid) begin
                own_hit = 1'b1;
                own_idx = IdxWidth'(i);
                if (entries[i].word_addr == wa) begin
                    sc_ok = 1'b1;
                end
            end
            if (!entries[i].valid) begin
                free_hit = 1'b1;
                free_idx = IdxWidth'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumReservations; i++) begin
                entries[i] <= '0;
            end
            victim <= '0;
        end else begin
            if (lr) begin
                if (own_hit) begin
                    entries[own_idx].word_addr <= wa;
                end else if (free_hit) begin
                    entries[free_idx] <= fresh;
                end else begin
                    entries[victim] <= fresh;
                    victim <= (victim == LastIdx) ? '0 : victim + 1'b1;
                end
            end
            for (int i = 0; i < NumReservations; i++) begin
                if (entries[i].valid &&
                    ((clear_addr && entries[i].word_addr == wa) ||
                     (clear_core && entries[i].core_id == cid))) begin
                    entries[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/tcdm_lrsc_adapter.sv
// Bank-side TCDM adapter: LR/SC reservations, credit flow control and
// an in-order response queue in front of a 1-cycle-latency SRAM bank.
module tcdm_lrsc_adapter
    import tcdm_adapter_pkg::*;
#(
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned MetaWidth       = 16,
    parameter int unsigned CoreIdWidth     = 8,
    parameter int unsigned NumReservations = 4,
    parameter int unsigned RespDepth       = 2,
    localparam int unsigned StrbWidth      = DataWidth / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_req_valid_i,
    output logic                   in_req_ready_o,
    input  logic [AddrWidth-1:0]   in_req_addr_i,
    input  logic                   in_req_write_i,
    input  logic [3:0]             in_req_amo_i,
    input  logic [DataWidth-1:0]   in_req_wdata_i,
    input  logic [StrbWidth-1:0]   in_req_be_i,
    input  logic [CoreIdWidth-1:0] in_req_core_id_i,
    input  logic [MetaWidth-1:0]   in_req_meta_i,
    output logic                   in_resp_valid_o,
    input  logic                   in_resp_ready_i,
    output logic [DataWidth-1:0]   in_resp_rdata_o,
    output logic [MetaWidth-1:0]   in_resp_meta_o,
    output logic                   bank_req_o,
    output logic                   bank_we_o,
    output logic [AddrWidth-3:0]   bank_addr_o,
    output logic [DataWidth-1:0]   bank_wdata_o,
    output logic [StrbWidth-1:0]   bank_be_o,
    output logic [3:0]             bank_amo_o,
    input  logic [DataWidth-1:0]   bank_rdata_i
);

    localparam int unsigned CreditWidth = $clog2(RespDepth + 1);
    localparam int unsigned QueueWidth = DataWidth + MetaWidth;

    logic [AddrWidth-3:0] word_addr;
    logic unused_addr;
    logic is_plain;
    logic is_lr;
    logic is_sc;
    logic has_resp;
    logic accept;
    logic sc_ok;
    logic sc_fail;
    logic rsv_lr;
    logic rsv_sc;
    logic rsv_inv;
    logic [CreditWidth-1:0] credits;
    logic take;
    logic give;
    resp_pipe_t pipe;
    logic [DataWidth-1:0] push_rdata;
    logic [QueueWidth-1:0] push_data;
    logic [QueueWidth-1:0] head;
    logic queue_empty;

    assign word_addr = in_req_addr_i[AddrWidth-1:2];
    assign unused_addr = ^in_req_addr_i[1:0];

    assign is_plain = (in_req_amo_i == AmoNone);
    assign is_lr = (in_req_amo_i == AmoLR);
    assign is_sc = (in_req_amo_i == AmoSC);
    assign has_resp = !(is_plain && in_req_write_i);

    assign in_req_ready_o = (credits != '0);
    assign accept = in_req_valid_i && in_req_ready_o;
    assign sc_fail = is_sc && !sc_ok;

    // LR and a winning SC reach the SRAM as a plain read / write.
    assign bank_req_o = accept && !sc_fail;
    assign bank_we_o = bank_req_o && (is_sc || (!is_lr && in_req_write_i));
    assign bank_addr_o = bank_req_o ? word_addr : '0;
    assign bank_wdata_o = bank_req_o ? in_req_wdata_i : '0;
    assign bank_be_o = bank_req_o ? in_req_be_i : '0;
    assign bank_amo_o = (bank_req_o && !is_lr && !is_sc) ? in_req_amo_i : AmoNone;

    assign rsv_lr = accept && is_lr;
    assign rsv_sc = accept && is_sc;
    assign rsv_inv = accept && !is_lr && !is_sc && (in_req_write_i || !is_plain);

    tcdm_reservation_table #(
        .NumReservations (NumReservations),
        .CoreIdWidth     (CoreIdWidth),
        .WordWidth       (AddrWidth - 2)
    ) i_table (
        .clk       (clk_i),
        .rst       (rst_i),
        .lr        (rsv_lr),
        .sc        (rsv_sc),
        .inv       (rsv_inv),
        .core_id   (in_req_core_id_i),
        .word_addr (word_addr),
        .sc_ok     (sc_ok)
    );

    // Credits cover both the pipeline slot and the queue entries.
    assign take = accept && has_resp;
    assign give = in_resp_valid_o && in_resp_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credits <= CreditWidth'(RespDepth);
        end else if (take && !give) begin
            credits <= credits - 1'b1;
        end else if (give && !take) begin
            credits <= credits + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe <= '0;
        end else begin
            pipe.has_resp <= take;
            pipe.is_sc <= is_sc;
            pipe.sc_result <= sc_fail;
            pipe.meta <= PipeMetaWidth'(in_req_meta_i);
        end
    end

    assign push_rdata = pipe.is_sc ? DataWidth'(pipe.sc_result) : bank_rdata_i;
    assign push_data = {push_rdata, MetaWidth'(pipe.meta)};

    fifo_v3 #(
        .FallThrough (1'b1),
        .DataWidth   (QueueWidth),
        .Depth       (RespDepth)
    ) i_resp_queue (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (pipe.has_resp),
        .data_in  (push_data),
        .pop      (give),
        .data_out (head),
        .empty    (queue_empty)
    );

    assign in_resp_valid_o = !queue_empty;
    assign in_resp_rdata_o = in_resp_valid_o ? head[QueueWidth-1:MetaWidth] : '0;
    assign in_resp_meta_o = in_resp_valid_o ? head[MetaWidth-1:0] : '0;

endmodule
